// File: rtl/stage4_serializer.sv
// Clocked boundary of the self-timed pipeline: accepts words over a 4-phase req/ack handshake,
// queues them in a small FIFO and shifts each out as a start / LSB-first data / stop frame.
module stage4_serializer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_req,
  output logic                        in_ack,
  output logic                        stage4_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DATA_W - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e state_q, state_d;

  logic req_meta_q, req_s_q;
  logic ack_q, ack_d;
  logic push, pop;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;

  // Full test uses the registered count, so a same-edge pop never makes room for this push.
  always_comb begin
    push  = 1'b0;
    ack_d = ack_q;
    if (!ack_q && req_s_q) begin
      if (count_q != CountFull) begin
        push  = 1'b1;
        ack_d = 1'b1;
      end
    end else if (ack_q && !req_s_q) begin
      ack_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serializer next state; shift_q[0] is always the bit currently on the line while in StData.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StStop;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          idx_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    unique case (state_d)
      StStart: line_d = 1'b0;
      StData:  line_d = shift_d[0];
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      req_meta_q <= in_req;
      req_s_q    <= req_meta_q;
      ack_q      <= ack_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
    end
  end

  // Storage needs no reset: entries are only readable once the pointers say so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ack      = ack_q;
  assign stage4_data = line_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_stage4_serializer.sv
// Directed bench for stage4_serializer: default instance (4 clocks/bit) and a 1 clock/bit one.
module tb_stage4_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       ack_a, ack_b, line_a, line_b, busy_a, busy_b;
  logic [2:0] count_a, count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stage4_serializer dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_data     (data_a),
    .in_req      (req_a),
    .in_ack      (ack_a),
    .stage4_data (line_a),
    .busy        (busy_a),
    .fifo_count  (count_a)
  );

  stage4_serializer #(
    .DATA_W       (8),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_data     (data_b),
    .in_req      (req_b),
    .in_ack      (ack_b),
    .stage4_data (line_b),
    .busy        (busy_b),
    .fifo_count  (count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_line(input int s);
    return (s != 0) ? line_b : line_a;
  endfunction

  function automatic logic get_ack(input int s);
    return (s != 0) ? ack_b : ack_a;
  endfunction

  // Expected line samples of one frame, sample i at bit i.
  function automatic logic [63:0] frame_bits(input logic [7:0] w, input int cpb);
    logic [9:0]  bits;
    logic [63:0] f;
    bits = {1'b1, w, 1'b0};
    f    = '0;
    for (int i = 0; i < 10 * cpb; i++) f[i] = bits[i / cpb];
    return f;
  endfunction

  task automatic send(input int s, input logic [7:0] d);
    int t;
    if (s == 0) begin data_a = d; req_a = 1'b1; end
    else begin data_b = d; req_b = 1'b1; end
    t = 0;
    while (get_ack(s) !== 1'b1 && t < 200) begin tick(); t++; end
    check("ack_rise_bound", 64'(t < 200), 64'd1);
    if (s == 0) req_a = 1'b0;
    else req_b = 1'b0;
    t = 0;
    while (get_ack(s) !== 1'b0 && t < 200) begin tick(); t++; end
    check("ack_fall_bound", 64'(t < 200), 64'd1);
  endtask

  task automatic rx(input string tag, input int s, input int cpb, input int n,
                    input logic [7:0] words [8], output int gaps);
    logic [63:0] got;
    int t;
    gaps = 0;
    for (int f = 0; f < n; f++) begin
      t = 0;
      while (get_line(s) !== 1'b0 && t < 500) begin tick(); t++; end
      check($sformatf("%s_start%0d", tag, f), 64'(t < 500), 64'd1);
      if (f > 0) gaps += t;
      got = '0;
      for (int i = 0; i < 10 * cpb; i++) begin
        got[i] = get_line(s);
        tick();
      end
      check($sformatf("%s_frame%0d", tag, f), got, frame_bits(words[f], cpb));
    end
  endtask

  task automatic burst_monitor(input int ncyc, output int maxc, output int viol,
                               output int pop_cyc, output int rise6_cyc);
    logic [2:0] pc;
    logic       pa;
    int         rises;
    maxc = 0; viol = 0; pop_cyc = -1; rise6_cyc = -1; rises = 0;
    pc = count_a;
    pa = ack_a;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (pc == 3'd4 && !pa && ack_a) viol++;
      if (int'(count_a) > maxc) maxc = int'(count_a);
      if (pc == 3'd4 && count_a == 3'd3 && pop_cyc < 0) pop_cyc = cyc;
      if (!pa && ack_a) begin
        rises++;
        if (rises == 6) rise6_cyc = cyc;
      end
      pc = count_a;
      pa = ack_a;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic [7:0]  wb [8];
    int hi, gaps, maxc, viol, pop_cyc, rise6, pe, t;

    // Reset held across clock edges.
    repeat (3) tick();
    check("rst_line", 64'(line_a), 64'd1);
    check("rst_ack", 64'(ack_a), 64'd0);
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    rst = 1'b0;
    hi  = 0;
    repeat (10) begin
      tick();
      if (line_a === 1'b1 && busy_a === 1'b0) hi++;
    end
    check("idle_after_rst", 64'(hi), 64'd10);

    // Single word 0xA5: ack three edges after req, 40-cycle frame.
    data_a = 8'hA5;
    req_a  = 1'b1;
    tick(); check("ack_e0", 64'(ack_a), 64'd0);
    tick(); check("ack_e1", 64'(ack_a), 64'd0);
    tick(); check("ack_e2", 64'(ack_a), 64'd1);
    check("push_count", 64'(count_a), 64'd1);
    check("line_before_pop", 64'(line_a), 64'd1);
    data_a = 8'h00;
    req_a  = 1'b0;
    got    = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      got[i] = line_a;
      if (i == 0) check("count_after_pop", 64'(count_a), 64'd0);
      if (i == 1) check("ack_hold_f1", 64'(ack_a), 64'd1);
      if (i == 2) check("ack_drop_f2", 64'(ack_a), 64'd0);
      if (i == 39) check("busy_last_stop", 64'(busy_a), 64'd1);
    end
    check("frame_a5", got, frame_bits(8'hA5, 4));
    tick();
    check("busy_after_stop", 64'(busy_a), 64'd0);
    check("line_after_stop", 64'(line_a), 64'd1);
    repeat (3) tick();

    // Burst 0x00..0x05: fills the FIFO, word 5 waits for the first pop.
    for (int k = 0; k < 8; k++) wb[k] = 8'(k);
    fork
      begin
        for (int k = 0; k < 6; k++) send(0, 8'(k));
      end
      rx("burst", 0, 4, 6, wb, gaps);
      burst_monitor(260, maxc, viol, pop_cyc, rise6);
    join
    check("burst_max_count", 64'(maxc), 64'd4);
    check("burst_ack_while_full", 64'(viol), 64'd0);
    check("burst_push_after_pop", 64'(rise6 - pop_cyc), 64'd1);
    check("burst_gaps", 64'(gaps), 64'd0);
    check("burst_idle_busy", 64'(busy_a), 64'd0);
    repeat (3) tick();

    // Push lands on the STOP->START pop edge while two words are queued.
    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
    fork
      begin
        data_a = 8'h11;
        req_a  = 1'b1;
        t = 0;
        while (ack_a !== 1'b1 && t < 50) begin tick(); t++; end
        check("simul_first_ack", 64'(t < 50), 64'd1);
        pe    = cyc;
        req_a = 1'b0;
        t = 0;
        while (ack_a !== 1'b0 && t < 50) begin tick(); t++; end
        send(0, 8'h22);
        send(0, 8'h33);
        check("simul_pre_count", 64'(count_a), 64'd2);
        t = 0;
        while (cyc < pe + 38 && t < 100) begin tick(); t++; end
        data_a = 8'h44;
        req_a  = 1'b1;
        tick();
        tick();
        check("simul_cnt_before", 64'(count_a), 64'd2);
        tick();
        check("simul_ack", 64'(ack_a), 64'd1);
        check("simul_cnt", 64'(count_a), 64'd2);
        check("simul_start_bit", 64'(line_a), 64'd0);
        req_a = 1'b0;
        t = 0;
        while (ack_a !== 1'b0 && t < 50) begin tick(); t++; end
      end
      rx("simul", 0, 4, 4, wb, gaps);
    join
    check("simul_gaps", 64'(gaps), 64'd0);
    repeat (3) tick();

    // Reset in the middle of a frame with a word still queued.
    send(0, 8'h00);
    send(0, 8'h3C);
    repeat (10) tick();
    check("rst_pre_line", 64'(line_a), 64'd0);
    check("rst_pre_count", 64'(count_a), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_line", 64'(line_a), 64'd1);
    check("rst_async_ack", 64'(ack_a), 64'd0);
    check("rst_async_count", 64'(count_a), 64'd0);
    check("rst_async_busy", 64'(busy_a), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    hi  = 0;
    repeat (30) begin
      tick();
      if (line_a === 1'b1 && busy_a === 1'b0 && count_a === 3'd0) hi++;
    end
    check("quiet_after_rst", 64'(hi), 64'd30);

    // One clock per bit, eight words so both pointers wrap twice.
    wb[0] = 8'hFF; wb[1] = 8'h01; wb[2] = 8'h80; wb[3] = 8'h3C;
    wb[4] = 8'hC3; wb[5] = 8'h55; wb[6] = 8'hAA; wb[7] = 8'h7E;
    fork
      begin
        for (int k = 0; k < 8; k++) send(1, wb[k]);
      end
      rx("cpb1", 1, 1, 8, wb, gaps);
    join
    tick();
    check("cpb1_end_busy", 64'(busy_b), 64'd0);
    check("cpb1_end_count", 64'(count_b), 64'd0);
    check("cpb1_end_line", 64'(line_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage4_serializer.md
# stage4_serializer

Final pipeline stage after stage 3. Accepts 8-bit results from the self-timed upstream stage over a 4-phase req/ack handshake, buffers them in a small FIFO, and shifts each one out on the single-bit `stage4_data` line as a UART-style frame. This is the only clocked block in the pipeline, and it is the boundary between the self-timed core and clocked observers.

## Interface
- DATA_W, 8, width of each result word
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and at least 2
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be at least 1
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  DATA_W  result word; upstream holds it stable while in_req=1
- in_req  input  1  4-phase request from upstream; asynchronous to clk
- in_ack  output  1  4-phase acknowledge to upstream; registered
- stage4_data  output  1  serial output; idles high; registered
- busy  output  1  high when the FIFO is non-empty or a frame is in progress
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH

## Operation
- Reset (asynchronous, effective immediately):
  - in_ack=0, stage4_data=1, busy=0, fifo_count=0.
  - Synchronizer flops=0, FSM=IDLE, FIFO pointers=0.
  - FIFO contents and any in-flight frame are discarded.
- Input synchronizer: in_req passes through 2 flops to give req_s. Only req_s is used internally.
- Handshake FSM, one bit in_ack:
  - in_ack=0, req_s=1, fifo_count<FIFO_DEPTH: push in_data, set in_ack=1.
  - in_ack=0, req_s=1, FIFO full: hold and push nothing. Retry every cycle until a slot frees.
  - in_ack=1, req_s=0: set in_ack=0. This completes the 4-phase cycle.
  - Otherwise in_ack holds its value.
  - The full test uses the registered fifo_count. A push and a pop in the same cycle do not make room for that push; the push waits 1 cycle.
- FIFO: circular buffer. Read and write pointers wrap modulo FIFO_DEPTH. On a simultaneous push and pop, fifo_count is unchanged.
- Serializer FSM, with states IDLE, START, DATA, STOP:
  - IDLE: stage4_data=1. If fifo_count>0: pop into the shift register, set stage4_data<=0, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA.
  - DATA: send DATA_W bits, LSB first, each for CLKS_PER_BIT cycles. After the last bit, drive 1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end:
    - if fifo_count>0: pop and go straight to START (start bit on the next cycle, no idle gap);
    - otherwise go to IDLE.
- Counters:
  - Bit-period counter counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index counts 0..DATA_W-1.
  - Both reset to 0 on each state entry.
- busy is registered: busy = (FSM≠IDLE) or (fifo_count≠0), taken from next-state values.

## Timing
- Let in_req rise before clock edge E0:
  - req_s=1 after edge E1;
  - push and in_ack=1 after edge E2, when not full.
  - Latency from req to ack is 3 edges.
- Ack drop: in_req falls before edge F0, and in_ack=0 after edge F2.
- Serial start, empty FIFO, IDLE: the edge after the push pops the word, and stage4_data=0 from that edge on.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles; the default is 40.
- Back-to-back frames: the stop bit of frame N is followed immediately by the start bit of frame N+1.
- in_data is sampled on the push edge only. Changes after in_ack=1 have no effect.
- Reset mid-frame: stage4_data goes to 1 asynchronously. After reset is released, stage4_data stays idle high until a new push.
- Reset while in_ack=1: in_ack=0. If upstream still holds in_req=1, req_s rises again after 2 edges and the held word is pushed again. This is accepted behaviour.

## Test plan
- Reset: assert rst for 3 cycles mid-stream.
  - Required: stage4_data=1, in_ack=0, fifo_count=0, busy=0.
  - Required: no serial activity until the next req.
- Single word 0xA5 at default parameters.
  - Required: ack 3 edges after req.
  - Required: line reads 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each level for 4 cycles; total 40 cycles.
  - Required: busy drops at the end of the stop bit.
- Burst of 0x00..0x05 sent with back-to-back handshakes.
  - Required: fifo_count reaches 4 and ack is withheld while full.
  - Required: all 6 frames appear contiguously, with no idle gap, in order 0x00..0x05.
- Simultaneous push/pop: a push arrives on the same edge as a STOP→START pop while the FIFO holds 2.
  - Required: fifo_count stays at 2.
  - Required: frame data order is preserved.
- Full FIFO with a pending req and a pop on the same edge.
  - Required: push and ack occur one cycle after the pop, not on the same edge.
- CLKS_PER_BIT=1, DATA_W=8, word 0xFF.
  - Required: frame is 10 cycles long: one 0, then nine 1s.
  - Required: bit-wrap and pointer-wrap correct over 8 words (pointer wraps twice).
